// File: rtl/dma_read_engine_if.sv
// Bus bundle for dma_read_engine: command/status, shell read request/response, FIFO write port.
// The engine connects through the master modport; the environment uses the slave modport.
`timescale 1ns/1ps
interface dma_read_engine_if #(
  parameter int unsigned CLADDR_WIDTH    = 42,
  parameter int unsigned CLDATA_WIDTH    = 512,
  parameter int unsigned LOG2_FIFO_DEPTH = 9
);
  logic                       start;
  logic [CLADDR_WIDTH-1:0]    addr;
  logic [31:0]                num_lines;
  logic                       idle;
  logic                       active;
  logic                       done;
  logic                       tx_re;
  logic [CLADDR_WIDTH-1:0]    tx_raddr;
  logic [1:0]                 tx_rlength;
  logic                       rx_rvalid;
  logic [CLDATA_WIDTH-1:0]    rx_rdata;
  logic                       rx_ralmostfull;
  logic                       fifo_we;
  logic [CLDATA_WIDTH-1:0]    fifo_wdata;
  logic [LOG2_FIFO_DEPTH-1:0] fifo_count;

  modport master (
    input  start, addr, num_lines, rx_rvalid, rx_rdata, rx_ralmostfull, fifo_count,
    output idle, active, done, tx_re, tx_raddr, tx_rlength, fifo_we, fifo_wdata
  );

  modport slave (
    output start, addr, num_lines, rx_rvalid, rx_rdata, rx_ralmostfull, fifo_count,
    input  idle, active, done, tx_re, tx_raddr, tx_rlength, fifo_we, fifo_wdata
  );
endinterface

// File: rtl/dma_read_engine.sv
// DMA read engine: issues aligned 1/2/4-line read bursts under FIFO credit and forwards responses.
// Optional macro DMA_READ_PERF_EN adds perf_cycles / perf_stall_cycles counters.
`timescale 1ns/1ps
module dma_read_engine #(
  parameter int unsigned CLADDR_WIDTH    = 42,
  parameter int unsigned CLDATA_WIDTH    = 512,
  parameter int unsigned LOG2_FIFO_DEPTH = 9,
  parameter int unsigned FIFO_CAPACITY   = 496
) (
  input  logic                clk,
  input  logic                reset_n,
  dma_read_engine_if.master   bus
`ifdef DMA_READ_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_stall_cycles
`endif
);

  // Credit arithmetic is wide enough that fifo_count + outstanding + burst never wraps.
  localparam int unsigned CNT_W = LOG2_FIFO_DEPTH + 3;

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_DRAIN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [CLADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [31:0]             remaining_q, remaining_d;
  logic [31:0]             expected_q, expected_d;
  logic [31:0]             received_q, received_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic                    idle_q, idle_d;
  logic                    active_q, active_d;
  logic                    done_q, done_d;
  logic                    tx_re_q, tx_re_d;
  logic [CLADDR_WIDTH-1:0] tx_raddr_q, tx_raddr_d;
  logic [1:0]              tx_rlength_q, tx_rlength_d;
  logic                    fifo_we_q, fifo_we_d;
  logic [CLDATA_WIDTH-1:0] fifo_wdata_q, fifo_wdata_d;

  logic [2:0]              burst;
  logic [1:0]              burst_enc;
  logic [CNT_W-1:0]        credit_sum;
  logic                    can_issue;
  logic                    issue;
  logic                    accept;

  // Largest burst allowed by remaining count and address alignment.
  always_comb begin
    burst     = 3'd1;
    burst_enc = 2'b00;
    if (remaining_q >= 32'd4 && next_addr_q[1:0] == 2'b00) begin
      burst     = 3'd4;
      burst_enc = 2'b11;
    end else if (remaining_q >= 32'd2 && !next_addr_q[0]) begin
      burst     = 3'd2;
      burst_enc = 2'b01;
    end
  end

  assign credit_sum = CNT_W'(bus.fifo_count) + outstanding_q + CNT_W'(burst);
  assign can_issue  = !bus.rx_ralmostfull && (credit_sum <= CNT_W'(FIFO_CAPACITY));
  assign issue      = (state_q == S_REQUEST) && (remaining_q != 32'd0) && can_issue;
  assign accept     = bus.rx_rvalid && ((state_q == S_REQUEST) || (state_q == S_DRAIN));

  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    remaining_d   = remaining_q;
    expected_d    = expected_q;
    received_d    = accept ? received_q + 32'd1 : received_q;
    outstanding_d = outstanding_q + (issue ? CNT_W'(burst) : CNT_W'(0))
                                  - (accept ? CNT_W'(1) : CNT_W'(0));
    tx_re_d       = 1'b0;
    tx_raddr_d    = tx_raddr_q;
    tx_rlength_d  = tx_rlength_q;
    fifo_we_d     = accept;
    fifo_wdata_d  = accept ? bus.rx_rdata : fifo_wdata_q;
    done_d        = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          next_addr_d   = bus.addr;
          remaining_d   = bus.num_lines;
          expected_d    = bus.num_lines;
          received_d    = 32'd0;
          outstanding_d = CNT_W'(0);
          state_d       = (bus.num_lines == 32'd0) ? S_DONE : S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (issue) begin
          tx_re_d      = 1'b1;
          tx_raddr_d   = next_addr_q;
          tx_rlength_d = burst_enc;
          next_addr_d  = next_addr_q + CLADDR_WIDTH'(burst);
          remaining_d  = remaining_q - 32'(burst);
          if (remaining_q == 32'(burst)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (received_d == expected_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    idle_d   = (state_d == S_IDLE);
    active_d = (state_d == S_REQUEST) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      next_addr_q   <= '0;
      remaining_q   <= '0;
      expected_q    <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      idle_q        <= 1'b1;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      tx_re_q       <= 1'b0;
      tx_raddr_q    <= '0;
      tx_rlength_q  <= 2'b00;
      fifo_we_q     <= 1'b0;
      fifo_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      remaining_q   <= remaining_d;
      expected_q    <= expected_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      idle_q        <= idle_d;
      active_q      <= active_d;
      done_q        <= done_d;
      tx_re_q       <= tx_re_d;
      tx_raddr_q    <= tx_raddr_d;
      tx_rlength_q  <= tx_rlength_d;
      fifo_we_q     <= fifo_we_d;
      fifo_wdata_q  <= fifo_wdata_d;
    end
  end

  assign bus.idle       = idle_q;
  assign bus.active     = active_q;
  assign bus.done       = done_q;
  assign bus.tx_re      = tx_re_q;
  assign bus.tx_raddr   = tx_raddr_q;
  assign bus.tx_rlength = tx_rlength_q;
  assign bus.fifo_we    = fifo_we_q;
  assign bus.fifo_wdata = fifo_wdata_q;

`ifdef DMA_READ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating activity / stall counters, cleared by an accepted start.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == S_IDLE && bus.start) begin
      perf_cycles_d = 32'd0;
      perf_stall_d  = 32'd0;
    end else begin
      if ((state_q == S_REQUEST || state_q == S_DRAIN) && perf_cycles_q != 32'hFFFF_FFFF)
        perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == S_REQUEST && remaining_q != 32'd0 && !can_issue &&
          perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles       = perf_cycles_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dma_read_engine.sv
// Scoreboard bench for dma_read_engine: directed scenarios plus randomized commands,
// a memory-shell responder model, and a monitor comparing requests, FIFO writes and done timing.
`timescale 1ns/1ps
module tb_dma_read_engine;
  localparam int unsigned AW  = 42;
  localparam int unsigned DW  = 512;
  localparam int unsigned CW  = 9;
  localparam int unsigned CAP = 496;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_read_engine_if #(.CLADDR_WIDTH(AW), .CLDATA_WIDTH(DW), .LOG2_FIFO_DEPTH(CW)) bus ();

`ifdef DMA_READ_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  dma_read_engine #(
    .CLADDR_WIDTH(AW), .CLDATA_WIDTH(DW), .LOG2_FIFO_DEPTH(CW), .FIFO_CAPACITY(CAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef DMA_READ_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct { logic [AW-1:0] a; logic [1:0] len; } req_t;
  typedef struct { logic [AW-1:0] a; int rdy; } pend_t;

  req_t          exp_req_q[$];
  logic [DW-1:0] exp_data_q[$];
  pend_t         pend_q[$];

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  last_we_cyc = 0;
  int  we_total = 0;
  int  tx_total = 0;
  int  lat = 2;
  int  gap_pct = 0;
  bit  af_rand = 1'b0;
  bit  exp_done = 1'b0;
  bit  zero_cmd = 1'b0;
  bit  done_seen = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [31:0] hi;
    hi = 32'hC0DE_0000 ^ {22'h0, a[AW-1:32]};
    return {8{a[31:0], hi}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory shell: each requested line returns in address order after 'lat' cycles.
  always @(negedge clk) begin
    if (reset_n && bus.tx_re) begin
      int n;
      n = (bus.tx_rlength == 2'b11) ? 4 : (bus.tx_rlength == 2'b01) ? 2 : 1;
      for (int i = 0; i < n; i++) pend_q.push_back('{a: bus.tx_raddr + AW'(i), rdy: cyc + lat});
    end
    bus.rx_rvalid = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].rdy <= cyc && $urandom_range(0, 99) >= gap_pct) begin
      bus.rx_rvalid = 1'b1;
      bus.rx_rdata  = data_of(pend_q[0].a);
      void'(pend_q.pop_front());
    end
    if (af_rand) bus.rx_ralmostfull = ($urandom_range(0, 9) < 2);
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.tx_re) begin
        tx_total++;
        if (exp_req_q.size() == 0) check("unexpected_tx_re", DW'(bus.tx_re), DW'(0));
        else begin
          req_t r;
          r = exp_req_q.pop_front();
          check("tx_raddr", DW'(bus.tx_raddr), DW'(r.a));
          check("tx_rlength", DW'(bus.tx_rlength), DW'(r.len));
        end
      end
      if (bus.fifo_we) begin
        we_total++;
        last_we_cyc = cyc;
        if (exp_data_q.size() == 0) check("unexpected_fifo_we", DW'(bus.fifo_we), DW'(0));
        else check("fifo_wdata", bus.fifo_wdata, exp_data_q.pop_front());
      end
      if (bus.done) begin
        if (!exp_done) check("unexpected_done", DW'(bus.done), DW'(0));
        else begin
          if (zero_cmd) check("done_latency_zero", DW'(cyc), DW'(start_cyc + 2));
          else          check("done_latency", DW'(cyc), DW'(last_we_cyc + 1));
          exp_done  = 1'b0;
          done_seen = 1'b1;
        end
      end
    end
  end

  // Reference model: split the command into bursts from alignment rules and list the lines.
  task automatic cmd(input logic [AW-1:0] a, input int unsigned n);
    logic [AW-1:0] x;
    int unsigned   rem, b;
    x = a;
    rem = n;
    while (rem > 0) begin
      if (rem >= 4 && x[1:0] == 2'b00)  b = 4;
      else if (rem >= 2 && x[0] == 1'b0) b = 2;
      else                               b = 1;
      exp_req_q.push_back('{a: x, len: (b == 4) ? 2'b11 : (b == 2) ? 2'b01 : 2'b00});
      x   = x + AW'(b);
      rem = rem - b;
    end
    for (int unsigned i = 0; i < n; i++) exp_data_q.push_back(data_of(a + AW'(i)));
    exp_done      = 1'b1;
    zero_cmd      = (n == 0);
    done_seen     = 1'b0;
    bus.addr      = a;
    bus.num_lines = n;
    bus.start     = 1'b1;
    start_cyc     = cyc;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clk);
    check("done_seen", DW'(done_seen), DW'(1));
    @(negedge clk);
    check("idle_after_done", DW'(bus.idle), DW'(1));
    check("req_queue_drained", DW'(exp_req_q.size()), DW'(0));
    check("data_queue_drained", DW'(exp_data_q.size()), DW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int txc, wec;
    bus.start = 1'b0;
    bus.addr = '0;
    bus.num_lines = '0;
    bus.rx_ralmostfull = 1'b0;
    bus.fifo_count = '0;
    repeat (3) @(negedge clk);
    check("rst_idle", DW'(bus.idle), DW'(1));
    check("rst_active", DW'(bus.active), DW'(0));
    check("rst_done", DW'(bus.done), DW'(0));
    check("rst_tx_re", DW'(bus.tx_re), DW'(0));
    check("rst_tx_raddr", DW'(bus.tx_raddr), DW'(0));
    check("rst_tx_rlength", DW'(bus.tx_rlength), DW'(0));
    check("rst_fifo_we", DW'(bus.fifo_we), DW'(0));
    check("rst_fifo_wdata", bus.fifo_wdata, DW'(0));
    reset_n = 1'b1;
    @(negedge clk);

    cmd(AW'(42'h100), 8);
    check("active_in_request", DW'(bus.active), DW'(1));
    check("not_idle_in_request", DW'(bus.idle), DW'(0));
    wait_done();

    cmd(AW'(42'h101), 6);
    wait_done();

    txc = tx_total;
    cmd(AW'(42'h3), 0);
    wait_done();
    check("zero_len_no_tx", DW'(tx_total - txc), DW'(0));

    // Credit limit: 494 + 4 exceeds capacity, 492 + 4 fits.
    bus.fifo_count = CW'(494);
    txc = tx_total;
    cmd(AW'(42'h200), 4);
    repeat (10) @(negedge clk);
    check("credit_block", DW'(tx_total - txc), DW'(0));
    check("credit_block_active", DW'(bus.active), DW'(1));
    bus.fifo_count = CW'(492);
    wait_done();
    check("credit_one_request", DW'(tx_total - txc), DW'(1));
    bus.fifo_count = '0;

    // Shell backpressure held through the start of the command.
    bus.rx_ralmostfull = 1'b1;
    txc = tx_total;
    cmd(AW'(42'h300), 16);
    repeat (12) @(negedge clk);
    check("almostfull_block", DW'(tx_total - txc), DW'(0));
    bus.rx_ralmostfull = 1'b0;
    wait_done();
    check("almostfull_requests", DW'(tx_total - txc), DW'(4));
`ifdef DMA_READ_PERF_EN
    check("perf_stall_ge10", DW'(perf_stall_cycles >= 32'd10), DW'(1));
    check("perf_cycles_gt_stall", DW'(perf_cycles > perf_stall_cycles), DW'(1));
`endif

    for (int it = 0; it < 10; it++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      lat = $urandom_range(1, 6);
      gap_pct = $urandom_range(0, 40);
      bus.fifo_count = CW'($urandom_range(0, 300));
      af_rand = 1'b1;
      cmd(AW'(ra), $urandom_range(0, 40));
      wait_done();
    end
    af_rand = 1'b0;
    @(negedge clk);
    bus.rx_ralmostfull = 1'b0;
    bus.fifo_count = '0;
    lat = 2;
    gap_pct = 0;

    // Reset while draining: in-flight lines must be dropped.
    wec = we_total;
    cmd(AW'(42'h400), 16);
    for (int i = 0; i < 500 && (we_total - wec) < 13; i++) @(negedge clk);
    check("pre_reset_lines", DW'(we_total - wec), DW'(13));
    reset_n = 1'b0;
    #1;
    check("reset_idle", DW'(bus.idle), DW'(1));
    check("reset_active", DW'(bus.active), DW'(0));
    check("reset_fifo_we", DW'(bus.fifo_we), DW'(0));
    exp_req_q.delete();
    exp_data_q.delete();
    exp_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wec = we_total;
    repeat (10) @(negedge clk);
    check("late_resp_dropped", DW'(we_total - wec), DW'(0));
    cmd(AW'(42'h500), 4);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
